// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and load/store,
// with data priority bounded by a streak counter and pipeline stall outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack,
  output logic                  StallF,
  output logic                  StallM
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e            state_q;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  ram_req_q, ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q, if_rdata_q, mem_rdata_q;
  logic                  if_ready_q, mem_ready_q;

  logic   data_pend;
  logic   grant_vld;
  owner_e grant_own;

  // Grant decision for IDLE: data wins unless the fetch has waited out the streak.
  always_comb begin
    data_pend = MemReadM | MemWriteM;
    grant_vld = 1'b0;
    grant_own = OWN_FETCH;
    if (data_pend && !(if_req && (streak_q == STREAK_MAX))) begin
      grant_vld = 1'b1;
      grant_own = OWN_DATA;
    end else if (if_req) begin
      grant_vld = 1'b1;
    end

    streak_d = streak_q;
    if (grant_vld) begin
      if ((grant_own == OWN_DATA) && if_req) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            streak_q  <= streak_d;
            ram_req_q <= 1'b1;
            if (grant_own == OWN_DATA) begin
              ram_we_q    <= MemWriteM;
              ram_addr_q  <= mem_addr;
              ram_wdata_q <= mem_wdata;
              state_q     <= DATA;
            end else begin
              ram_we_q   <= 1'b0;
              ram_addr_q <= if_addr;
              state_q    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (ram_ack) begin
            if_rdata_q <= ram_rdata;
            if_ready_q <= 1'b1;
            ram_req_q  <= 1'b0;
            state_q    <= RESP;
          end
        end
        DATA: begin
          if (ram_ack) begin
            // Stores leave the last load data untouched.
            if (!ram_we_q) begin
              mem_rdata_q <= ram_rdata;
            end
            mem_ready_q <= 1'b1;
            ram_req_q   <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;

  assign StallF = if_req & ~if_ready_q;
  assign StallM = (MemReadM | MemWriteM) & ~mem_ready_q;

endmodule
